mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single-ported synchronous RAM.
// Each access takes IDLE -> ISSUE -> COMPLETE, and done pulses on the return to IDLE.
module mem_arbiter #(
  parameter int BITS    = 32,
  parameter int RAMSIZE = 512,
  parameter int ADDR    = $clog2(RAMSIZE)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_req,
  input  logic            a_write,
  input  logic [ADDR-1:0] a_addr,
  input  logic [BITS-1:0] a_wdata,
  output logic            a_done,
  output logic [BITS-1:0] a_rdata,
  input  logic            b_req,
  input  logic            b_write,
  input  logic [ADDR-1:0] b_addr,
  input  logic [BITS-1:0] b_wdata,
  output logic            b_done,
  output logic [BITS-1:0] b_rdata,
  output logic            ram_read,
  output logic            ram_write,
  output logic [ADDR-1:0] ram_addr,
  output logic [BITS-1:0] ram_wdata,
  input  logic [BITS-1:0] ram_rdata,
  output logic            busy
);

  // state    | meaning
  // IDLE     | arbitrating; done pulse of the previous access is visible here
  // ISSUE    | RAM strobe asserted with the latched address/data
  // COMPLETE | RAM read data available, captured into the granted port
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_COMPLETE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            last_grant_q, last_grant_d;   // 0 = A, 1 = B
  logic            sel_q, sel_d;
  logic            write_q, write_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [BITS-1:0] wdata_q, wdata_d;
  logic            a_done_q, a_done_d;
  logic            b_done_q, b_done_d;
  logic [BITS-1:0] a_rdata_q, a_rdata_d;
  logic [BITS-1:0] b_rdata_q, b_rdata_d;
  logic            a_elig, b_elig, grant_b;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    a_done_d     = 1'b0;
    b_done_d     = 1'b0;
    // A port whose done is showing is still holding req from the finished access.
    a_elig       = a_req & ~a_done_q;
    b_elig       = b_req & ~b_done_q;
    grant_b      = b_elig & (~a_elig | ~last_grant_q);
    case (state_q)
      ST_IDLE: begin
        if (a_elig || b_elig) begin
          state_d      = ST_ISSUE;
          sel_d        = grant_b;
          last_grant_d = grant_b;
          write_d      = grant_b ? b_write : a_write;
          addr_d       = grant_b ? b_addr  : a_addr;
          wdata_d      = grant_b ? b_wdata : a_wdata;
        end
      end
      ST_ISSUE: state_d = ST_COMPLETE;
      ST_COMPLETE: begin
        state_d = ST_IDLE;
        if (!write_q) begin
          if (sel_q) b_rdata_d = ram_rdata;
          else       a_rdata_d = ram_rdata;
        end
        a_done_d = ~sel_q;
        b_done_d = sel_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      a_done_q     <= 1'b0;
      b_done_q     <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      a_done_q     <= a_done_d;
      b_done_q     <= b_done_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  assign ram_read  = (state_q == ST_ISSUE) & ~write_q;
  assign ram_write = (state_q == ST_ISSUE) &  write_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign a_done    = a_done_q;
  assign b_done    = b_done_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
